csa_resolve: RTL

CSA_RESOLVE -- requirements
Module: csa_resolve

---
 rtl/csa_resolve.sv | 119 +++++++++++
 1 files changed

// File: rtl/csa_resolve.sv
// csa_resolve: resolves a carry-save pair into binary, SEG bits per clock.
// Define CSA_RESOLVE_SAT_EN for a saturating sum on carry-out.
module csa_resolve #(
   parameter int MAX = 7,
   parameter int SEG = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [MAX-1:0] pv_s,
   input  logic [MAX-1:0] pv_c,
   input  logic           in_valid,
   output logic           in_ready,
   output logic [MAX-1:0] sum,
   output logic           cout,
   output logic           out_valid,
   input  logic           out_ready
);
   localparam int NSEG    = (MAX + SEG - 1) / SEG;
   localparam int LAST_LO = (NSEG - 1) * SEG;
   localparam int LAST_W  = MAX - LAST_LO;
   localparam int SW      = SEG + 1;
   localparam int IW      = (NSEG > 1) ? $clog2(NSEG) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NSEG - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]     state_reg;
   logic [MAX-1:0] s_reg;
   logic [MAX-1:0] c_reg;
   logic [MAX-1:0] sum_reg;
   logic [IW-1:0]  idx_reg;
   logic           carry_reg;
   logic           cout_reg;
   logic           out_valid_reg;

   logic [SEG-1:0] s_seg [NSEG];
   logic [SEG-1:0] c_seg [NSEG];
   logic [MAX-1:0] sum_calc;
   logic [SW-1:0]  seg_res;

   // The short top segment is zero-padded, so its carry-out of bit MAX-1
   // lands at seg_res[LAST_W] rather than at seg_res[SEG].
   for (genvar gi = 0; gi < NSEG; gi++) begin : g_seg
      if (gi < NSEG - 1) begin : g_full
         assign s_seg[gi] = s_reg[gi*SEG +: SEG];
         assign c_seg[gi] = c_reg[gi*SEG +: SEG];
         assign sum_calc[gi*SEG +: SEG] = (idx_reg == IW'(gi)) ?
                                          seg_res[SEG-1:0] : sum_reg[gi*SEG +: SEG];
      end else begin : g_last
         assign s_seg[gi] = SEG'(s_reg[MAX-1:LAST_LO]);
         assign c_seg[gi] = SEG'(c_reg[MAX-1:LAST_LO]);
         assign sum_calc[MAX-1:LAST_LO] = (idx_reg == LAST_IDX) ?
                                          seg_res[LAST_W-1:0] : sum_reg[MAX-1:LAST_LO];
      end
   end

   always_comb begin
      seg_res = {1'b0, s_seg[idx_reg]} + {1'b0, c_seg[idx_reg]} + SW'(carry_reg);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         s_reg         <= '0;
         c_reg         <= '0;
         sum_reg       <= '0;
         idx_reg       <= '0;
         carry_reg     <= 1'b0;
         cout_reg      <= 1'b0;
         out_valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  s_reg     <= pv_s;
                  c_reg     <= pv_c;
                  carry_reg <= 1'b0;
                  idx_reg   <= '0;
                  state_reg <= CALC;
               end
            end
            CALC: begin
               sum_reg   <= sum_calc;
               carry_reg <= seg_res[SEG];
               idx_reg   <= idx_reg + 1'b1;
               if (idx_reg == LAST_IDX) begin
                  cout_reg      <= seg_res[LAST_W];
                  idx_reg       <= '0;
                  out_valid_reg <= 1'b1;
                  state_reg     <= DONE;
`ifdef CSA_RESOLVE_SAT_EN
                  if (seg_res[LAST_W]) begin
                     sum_reg <= '1;
                  end
`endif
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_reg <= 1'b0;
                  state_reg     <= IDLE;
               end
            end
            default: begin
               out_valid_reg <= 1'b0;
               state_reg     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = (state_reg == IDLE);
   assign sum       = sum_reg;
   assign cout      = cout_reg;
   assign out_valid = out_valid_reg;

endmodule
